alu: RTL and testbench

8-bit arithmetic/logic unit for the team's single-cycle processor datapath. It takes two register-file operands and a 3-bit opcode from the control decoder. It returns the result plus zero, parity and shift/carry-out indications. All results are combinational; a small registered status copy is kept for condition tests in the following cycle.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_shifter.sv | 19 +
 rtl/alu.sv | 53 +++++
 tb/tb_alu.sv | 132 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode enum and data width for the ALU and control decoder
package alu_pkg;
  localparam int DW = 8;
  typedef enum logic [2:0] {
    AND  = 3'd0,
    ADD  = 3'd1,
    SUB  = 3'd2,
    OR   = 3'd3,
    LSH  = 3'd4,
    RSH  = 3'd5,
    CMP  = 3'd6,
    PASS = 3'd7
  } alu_op_t;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: logical shift of val by the full 8-bit amt; right=1 shifts right; sco is the last bit shifted out
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DW-1:0] val,
  input  logic [DW-1:0] amt,
  input  logic          right,
  output logic [DW-1:0] shifted,
  output logic          sco
);
  logic [DW:0] lsh, rsh;
  logic        big;
  // A guard bit above (left) or below (right) the value catches the last bit shifted out.
  assign lsh = {1'b0, val} << amt[3:0];
  assign rsh = {val, 1'b0} >> amt[3:0];
  assign big = amt > 8'(DW);
  assign shifted = big ? '0 : right ? rsh[DW:1] : lsh[DW-1:0];
  assign sco = big ? 1'b0 : right ? rsh[0] : lsh[DW];
endmodule

// File: rtl/alu.sv
// alu: 8-bit combinational ALU (Rslt/Zero/Par/SCo) with registered flag copies (ZeroQ/ParQ/SCoQ), async active-high Reset
module alu
  import alu_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic [DW-1:0] DatA,
  input  logic [DW-1:0] DatB,
  input  logic [2:0]    ALUop,
  output logic [DW-1:0] Rslt,
  output logic          Zero,
  output logic          Par,
  output logic          SCo,
  output logic          ZeroQ,
  output logic          ParQ,
  output logic          SCoQ
);
  alu_op_t     op;
  logic [DW:0] sum, diff;
  logic [DW-1:0] sh;
  logic        sh_co;
  assign op = alu_op_t'(ALUop);
  assign sum = {1'b0, DatA} + {1'b0, DatB};
  // Bit DW of the widened difference is the unsigned borrow.
  assign diff = {1'b0, DatA} - {1'b0, DatB};
  alu_shifter u_shifter (
    .val    (DatB),
    .amt    (DatA),
    .right  (op == RSH),
    .shifted(sh),
    .sco    (sh_co)
  );
  always_comb begin
    Rslt = '0;
    SCo = 1'b0;
    case (op)
      AND:  Rslt = DatA & DatB;
      ADD:  {SCo, Rslt} = sum;
      SUB:  {SCo, Rslt} = diff;
      OR:   Rslt = DatA | DatB;
      LSH,
      RSH:  {SCo, Rslt} = {sh_co, sh};
      CMP:  Rslt = {6'd0, DatA > DatB, DatA != DatB};
      PASS: Rslt = DatB;
      default: Rslt = '0;
    endcase
  end
  assign Zero = Rslt == '0;
  assign Par = ^Rslt;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) {ZeroQ, ParQ, SCoQ} <= 3'b000;
    else {ZeroQ, ParQ, SCoQ} <= {Zero, Par, SCo};
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed test plan plus random stimulus against an arithmetic reference model
module tb_alu;
  import alu_pkg::*;
  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] DatA, DatB;
  logic [2:0] ALUop;
  logic [7:0] Rslt;
  logic       Zero, Par, SCo, ZeroQ, ParQ, SCoQ;
  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] last_flags;

  alu dut (
    .Clk(Clk), .Reset(Reset), .DatA(DatA), .DatB(DatB), .ALUop(ALUop),
    .Rslt(Rslt), .Zero(Zero), .Par(Par), .SCo(SCo),
    .ZeroQ(ZeroQ), .ParQ(ParQ), .SCoQ(SCoQ)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {SCo, Rslt} from the operation rules using integer arithmetic.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int ia = int'(a);
    int ib = int'(b);
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return 9'(ia + ib);
      3'd2: return {a < b, 8'(ia - ib)};
      3'd3: return {1'b0, a | b};
      3'd4: return (ia >= 9) ? 9'd0 : 9'(ib << ia);
      3'd5: return (ia == 0) ? {1'b0, b} : (ia > 8) ? 9'd0 : {1'(ib >> (ia - 1)), 8'(ib >> ia)};
      3'd6: return {1'b0, 6'd0, a > b, a != b};
      default: return {1'b0, b};
    endcase
  endfunction

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [8:0] e;
    @(negedge Clk);
    DatA = a; DatB = b; ALUop = op;
    #1;
    e = model(a, b, op);
    chk("rslt", 9'(Rslt), 9'(e[7:0]));
    chk("sco", 9'(SCo), 9'(e[8]));
    chk("zero", 9'(Zero), 9'(e[7:0] == 8'd0));
    chk("par", 9'(Par), 9'(^e[7:0]));
    last_flags = {e[7:0] == 8'd0, ^e[7:0], e[8]};
  endtask

  task automatic plan(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [7:0] er, input logic es);
    step(a, b, op);
    chk("plan_rslt", 9'(Rslt), 9'(er));
    chk("plan_sco", 9'(SCo), 9'(es));
  endtask

  task automatic tick_check();
    @(posedge Clk);
    #1;
    chk("flagq", 9'({ZeroQ, ParQ, SCoQ}), 9'(last_flags));
  endtask

  initial begin
    Reset = 1'b1; DatA = 8'd0; DatB = 8'd0; ALUop = 3'd0;
    #1;
    chk("reset_q", 9'({ZeroQ, ParQ, SCoQ}), 9'd0);
    chk("reset_comb_zero", 9'(Zero), 9'd1);
    @(posedge Clk);
    #1;
    chk("reset_held_q", 9'({ZeroQ, ParQ, SCoQ}), 9'd0);
    @(negedge Clk);
    Reset = 1'b0;
    plan(8'd1, 8'd1, 3'd0, 8'h01, 1'b0);
    chk("and_par", 9'(Par), 9'd1);
    tick_check();
    plan(8'd4, 8'd1, 3'd4, 8'h10, 1'b0);
    plan(8'd1, 8'h80, 3'd4, 8'h00, 1'b1);
    chk("lsh_zero", 9'(Zero), 9'd1);
    tick_check();
    plan(8'd9, 8'hFF, 3'd4, 8'h00, 1'b0);
    plan(8'd8, 8'h01, 3'd4, 8'h00, 1'b1);
    plan(8'd0, 8'h5A, 3'd4, 8'h5A, 1'b0);
    plan(8'd3, 8'd5, 3'd2, 8'hFE, 1'b1);
    plan(8'd5, 8'd3, 3'd2, 8'h02, 1'b0);
    plan(8'd1, 8'h03, 3'd5, 8'h01, 1'b1);
    plan(8'd0, 8'hA5, 3'd5, 8'hA5, 1'b0);
    plan(8'd8, 8'h80, 3'd5, 8'h00, 1'b1);
    plan(8'd200, 8'hFF, 3'd5, 8'h00, 1'b0);
    plan(8'd7, 8'd3, 3'd6, 8'h03, 1'b0);
    plan(8'd3, 8'd7, 3'd6, 8'h01, 1'b0);
    plan(8'd5, 8'd5, 3'd6, 8'h00, 1'b0);
    chk("cmp_zero", 9'(Zero), 9'd1);
    plan(8'hF0, 8'h0F, 3'd3, 8'hFF, 1'b0);
    chk("or_par", 9'(Par), 9'd0);
    plan(8'h33, 8'h07, 3'd7, 8'h07, 1'b0);
    chk("pass_par", 9'(Par), 9'd1);
    plan(8'hFF, 8'h01, 3'd1, 8'h00, 1'b1);
    chk("add_zero", 9'(Zero), 9'd1);
    tick_check();
    chk("scoq_set", 9'(SCoQ), 9'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_reset_q", 9'({ZeroQ, ParQ, SCoQ}), 9'd0);
    chk("reset_comb_sco", 9'(SCo), 9'd1);
    @(posedge Clk);
    #1;
    chk("reset_hold_q", 9'({ZeroQ, ParQ, SCoQ}), 9'd0);
    @(negedge Clk);
    Reset = 1'b0;
    step(8'd3, 8'd5, 3'd2);
    tick_check();
    chk("release_capture", 9'({ZeroQ, ParQ, SCoQ}), 9'b011);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      a = (i % 2 == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      step(a, 8'($urandom), 3'($urandom));
      tick_check();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
